pa_clic_arb_pipe: RTL and testbench

- Downstream consumer of the per-interrupt CLIC kid cells.
- Collects every kid's req/hv/int_all, selects the highest-priority pending-and-enabled interrupt in a 2-stage pipelined tournament, applies the threshold filter, and presents a registered winner to the core interrupt-take logic.
- Dummy kid slots drive all-zero and therefore never win.

---
 rtl/pa_clic_arb_pipe.sv | 117 +++++++++++
 tb/tb_pa_clic_arb_pipe.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pa_clic_arb_pipe.sv
// CLIC arbiter: 2-stage tournament over kid slots with threshold filter and hold.
// Define CLIC_ARB_SINGLE_STAGE_EN to drop the stage-1 registers (1-cycle latency).
`ifndef CLIC_INTCTLBITS
`define CLIC_INTCTLBITS 3
`endif

module pa_clic_arb_pipe #(
    parameter int unsigned NUM_INT        = 64,
    parameter int unsigned CLICINTCTLBITS = `CLIC_INTCTLBITS,
    parameter int unsigned INT_ID_W       = 12
) (
    input  logic                                    forever_cpuclk,
    input  logic                                    cpurst_b,
    input  logic [NUM_INT-1:0]                      kid_arb_int_req,
    input  logic [NUM_INT-1:0]                      kid_arb_int_hv,
    input  logic [NUM_INT*(CLICINTCTLBITS+1)-1:0]   kid_arb_int_all,
    input  logic [CLICINTCTLBITS-1:0]               clic_mintthresh,
    input  logic                                    ctrl_arb_int_hold,
    output logic                                    arb_ctrl_int_vld,
    output logic [INT_ID_W-1:0]                     arb_ctrl_int_id,
    output logic [CLICINTCTLBITS-1:0]               arb_ctrl_int_ctl,
    output logic                                    arb_ctrl_int_hv
);

    localparam int unsigned NUM_GRP = NUM_INT / 4;
    localparam int unsigned SLOT_W  = CLICINTCTLBITS + 1;

    if (NUM_INT > (64'd1 << INT_ID_W)) begin : g_id_w_chk
        $error("pa_clic_arb_pipe: NUM_INT exceeds 2**INT_ID_W");
    end
    if ((NUM_INT % 4) != 0 || NUM_INT < 4 || NUM_INT > 64) begin : g_num_int_chk
        $error("pa_clic_arb_pipe: NUM_INT must be a multiple of 4 in 4..64");
    end

    logic [NUM_GRP-1:0]                     grp_vld_d, grp_vld_q;
    logic [NUM_GRP-1:0][1:0]                grp_idx_d, grp_idx_q;
    logic [NUM_GRP-1:0][CLICINTCTLBITS-1:0] grp_ctl_d, grp_ctl_q;
    logic [NUM_GRP-1:0]                     grp_hv_d,  grp_hv_q;

    // Ascending scan with >= lets the higher slot index win a ctl tie.
    always_comb begin
        grp_vld_d = '0;
        grp_idx_d = '0;
        grp_ctl_d = '0;
        grp_hv_d  = '0;
        for (int g = 0; g < int'(NUM_GRP); g++) begin
            for (int s = 0; s < 4; s++) begin
                if (kid_arb_int_req[g*4+s] && kid_arb_int_all[(g*4+s)*SLOT_W] &&
                    (!grp_vld_d[g] ||
                     kid_arb_int_all[(g*4+s)*SLOT_W+1 +: CLICINTCTLBITS] >= grp_ctl_d[g])) begin
                    grp_vld_d[g] = 1'b1;
                    grp_idx_d[g] = 2'(s);
                    grp_ctl_d[g] = kid_arb_int_all[(g*4+s)*SLOT_W+1 +: CLICINTCTLBITS];
                    grp_hv_d[g]  = kid_arb_int_hv[g*4+s];
                end
            end
        end
    end

`ifdef CLIC_ARB_SINGLE_STAGE_EN
    assign grp_vld_q = grp_vld_d;
    assign grp_idx_q = grp_idx_d;
    assign grp_ctl_q = grp_ctl_d;
    assign grp_hv_q  = grp_hv_d;
`else
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            grp_vld_q <= '0;
            grp_idx_q <= '0;
            grp_ctl_q <= '0;
            grp_hv_q  <= '0;
        end else begin
            grp_vld_q <= grp_vld_d;
            grp_idx_q <= grp_idx_d;
            grp_ctl_q <= grp_ctl_d;
            grp_hv_q  <= grp_hv_d;
        end
    end
`endif

    logic                      cand_vld;
    logic [INT_ID_W-1:0]       cand_id;
    logic [CLICINTCTLBITS-1:0] cand_ctl;
    logic                      cand_hv;
    logic                      pass_vld;

    always_comb begin
        cand_vld = 1'b0;
        cand_id  = '0;
        cand_ctl = '0;
        cand_hv  = 1'b0;
        for (int g = 0; g < int'(NUM_GRP); g++) begin
            if (grp_vld_q[g] && (!cand_vld || grp_ctl_q[g] >= cand_ctl)) begin
                cand_vld = 1'b1;
                cand_id  = INT_ID_W'(g * 4) + INT_ID_W'(grp_idx_q[g]);
                cand_ctl = grp_ctl_q[g];
                cand_hv  = grp_hv_q[g];
            end
        end
        pass_vld = cand_vld && (cand_ctl > clic_mintthresh);
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            arb_ctrl_int_vld <= 1'b0;
            arb_ctrl_int_id  <= '0;
            arb_ctrl_int_ctl <= '0;
            arb_ctrl_int_hv  <= 1'b0;
        end else if (!ctrl_arb_int_hold) begin
            arb_ctrl_int_vld <= pass_vld;
            arb_ctrl_int_id  <= pass_vld ? cand_id  : '0;
            arb_ctrl_int_ctl <= pass_vld ? cand_ctl : '0;
            arb_ctrl_int_hv  <= pass_vld && cand_hv;
        end
    end

endmodule

// File: tb/tb_pa_clic_arb_pipe.sv
// Self-checking bench for pa_clic_arb_pipe: directed scenarios plus randomized
// traffic against a flat-scan reference model with a latency delay line.
module tb_pa_clic_arb_pipe;

    localparam int NUM_INT = 64;
    localparam int CB      = 3;
`ifdef CLIC_ARB_SINGLE_STAGE_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    typedef struct packed {
        logic        vld;
        logic [11:0] id;
        logic [2:0]  ctl;
        logic        hv;
    } res_t;

    logic                        forever_cpuclk = 1'b0;
    logic                        cpurst_b = 1'b0;
    logic [NUM_INT-1:0]          kid_arb_int_req = '0;
    logic [NUM_INT-1:0]          kid_arb_int_hv = '0;
    logic [NUM_INT*(CB+1)-1:0]   kid_arb_int_all = '0;
    logic [CB-1:0]               clic_mintthresh = '0;
    logic                        ctrl_arb_int_hold = 1'b0;
    logic                        arb_ctrl_int_vld;
    logic [11:0]                 arb_ctrl_int_id;
    logic [CB-1:0]               arb_ctrl_int_ctl;
    logic                        arb_ctrl_int_hv;

    int vectors = 0;
    int miscompares = 0;

    pa_clic_arb_pipe #(
        .NUM_INT(NUM_INT),
        .CLICINTCTLBITS(CB),
        .INT_ID_W(12)
    ) dut (
        .forever_cpuclk(forever_cpuclk),
        .cpurst_b(cpurst_b),
        .kid_arb_int_req(kid_arb_int_req),
        .kid_arb_int_hv(kid_arb_int_hv),
        .kid_arb_int_all(kid_arb_int_all),
        .clic_mintthresh(clic_mintthresh),
        .ctrl_arb_int_hold(ctrl_arb_int_hold),
        .arb_ctrl_int_vld(arb_ctrl_int_vld),
        .arb_ctrl_int_id(arb_ctrl_int_id),
        .arb_ctrl_int_ctl(arb_ctrl_int_ctl),
        .arb_ctrl_int_hv(arb_ctrl_int_hv)
    );

    always #5 forever_cpuclk = ~forever_cpuclk;

    res_t dut_res;
    assign dut_res = {arb_ctrl_int_vld, arb_ctrl_int_id, arb_ctrl_int_ctl, arb_ctrl_int_hv};

    function automatic res_t mk(logic v, int id, int c, logic h);
        res_t r;
        r.vld = v;
        r.id  = 12'(id);
        r.ctl = 3'(c);
        r.hv  = h;
        return r;
    endfunction

    // Reference: highest ctl first, then highest slot index, among eligible slots.
    function automatic res_t scan();
        for (int c = 7; c >= 0; c--) begin
            for (int i = NUM_INT - 1; i >= 0; i--) begin
                if (kid_arb_int_req[i] && kid_arb_int_all[i*4] &&
                    int'(kid_arb_int_all[i*4+1 +: 3]) == c)
                    return mk(1'b1, i, c, kid_arb_int_hv[i]);
            end
        end
        return '0;
    endfunction

    function automatic res_t thresh(res_t c, logic [2:0] mt);
        if (c.vld && c.ctl > mt) return c;
        return '0;
    endfunction

    res_t m_s1, m_out;
    always @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            m_s1  <= '0;
            m_out <= '0;
        end else begin
            m_s1 <= scan();
            if (!ctrl_arb_int_hold) begin
`ifdef CLIC_ARB_SINGLE_STAGE_EN
                m_out <= thresh(scan(), clic_mintthresh);
`else
                m_out <= thresh(m_s1, clic_mintthresh);
`endif
            end
        end
    end

    task automatic tick(int n);
        repeat (n) @(negedge forever_cpuclk);
    endtask

    task automatic clear_all();
        kid_arb_int_req = '0;
        kid_arb_int_hv  = '0;
        kid_arb_int_all = '0;
    endtask

    task automatic set_slot(int i, logic r, logic v, int c, logic h);
        kid_arb_int_req[i]       = r;
        kid_arb_int_hv[i]        = h;
        kid_arb_int_all[i*4 +: 4] = {3'(c), v};
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if (dut_res !== res_t'(0)) begin
            miscompares++;
            $display("FAIL reset_initial: got %h want %h", dut_res, res_t'(0));
        end
        set_slot(5, 1'b1, 1'b1, 3, 1'b0);
        clic_mintthresh = 0;
        tick(1);
        cpurst_b = 1'b1;
        tick(LAT + 1);
        vectors++;
        if (dut_res !== mk(1, 5, 3, 0)) begin
            miscompares++;
            $display("FAIL reset_run: got %h want %h", dut_res, mk(1, 5, 3, 0));
        end
        #2 cpurst_b = 1'b0;
        #1;
        vectors++;
        if (dut_res !== res_t'(0)) begin
            miscompares++;
            $display("FAIL reset_async: got %h want %h", dut_res, res_t'(0));
        end
        tick(1);
        cpurst_b = 1'b1;
        tick(LAT - 1);
        vectors++;
        if (arb_ctrl_int_vld !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_early_vld: got %b want 0", arb_ctrl_int_vld);
        end
        tick(1);
        vectors++;
        if (dut_res !== mk(1, 5, 3, 0)) begin
            miscompares++;
            $display("FAIL reset_release: got %h want %h", dut_res, mk(1, 5, 3, 0));
        end
    endtask

    task automatic test_single();
        clear_all();
        set_slot(37, 1'b1, 1'b1, 5, 1'b1);
        clic_mintthresh = 2;
        tick(LAT);
        vectors++;
        if (dut_res !== mk(1, 37, 5, 1)) begin
            miscompares++;
            $display("FAIL single: got %h want %h", dut_res, mk(1, 37, 5, 1));
        end
    endtask

    task automatic test_priority();
        clear_all();
        clic_mintthresh = 0;
        set_slot(3, 1'b1, 1'b1, 4, 1'b0);
        set_slot(10, 1'b1, 1'b1, 6, 1'b0);
        set_slot(62, 1'b1, 1'b1, 6, 1'b1);
        tick(LAT);
        vectors++;
        if (dut_res !== mk(1, 62, 6, 1)) begin
            miscompares++;
            $display("FAIL prio_tie: got %h want %h", dut_res, mk(1, 62, 6, 1));
        end
        set_slot(62, 1'b0, 1'b1, 6, 1'b1);
        tick(LAT);
        vectors++;
        if (dut_res !== mk(1, 10, 6, 0)) begin
            miscompares++;
            $display("FAIL prio_drop: got %h want %h", dut_res, mk(1, 10, 6, 0));
        end
    endtask

    task automatic test_threshold();
        clear_all();
        set_slot(8, 1'b1, 1'b1, 2, 1'b0);
        clic_mintthresh = 2;
        tick(LAT);
        vectors++;
        if (dut_res !== res_t'(0)) begin
            miscompares++;
            $display("FAIL thresh_equal: got %h want %h", dut_res, res_t'(0));
        end
        clic_mintthresh = 1;
        tick(LAT);
        vectors++;
        if (dut_res !== mk(1, 8, 2, 0)) begin
            miscompares++;
            $display("FAIL thresh_pass: got %h want %h", dut_res, mk(1, 8, 2, 0));
        end
    endtask

    task automatic test_hold();
        clear_all();
        clic_mintthresh = 0;
        set_slot(10, 1'b1, 1'b1, 6, 1'b0);
        tick(LAT);
        vectors++;
        if (dut_res !== mk(1, 10, 6, 0)) begin
            miscompares++;
            $display("FAIL hold_pre: got %h want %h", dut_res, mk(1, 10, 6, 0));
        end
        ctrl_arb_int_hold = 1'b1;
        set_slot(20, 1'b1, 1'b1, 7, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick(1);
            vectors++;
            if (dut_res !== mk(1, 10, 6, 0)) begin
                miscompares++;
                $display("FAIL hold_frozen[%0d]: got %h want %h", k, dut_res, mk(1, 10, 6, 0));
            end
        end
        ctrl_arb_int_hold = 1'b0;
        tick(1);
        vectors++;
        if (dut_res !== mk(1, 20, 7, 1)) begin
            miscompares++;
            $display("FAIL hold_release: got %h want %h", dut_res, mk(1, 20, 7, 1));
        end
    endtask

    task automatic test_ineligible();
        clear_all();
        clic_mintthresh = 0;
        set_slot(15, 1'b1, 1'b0, 7, 1'b1);
        set_slot(2, 1'b1, 1'b1, 1, 1'b0);
        tick(LAT);
        vectors++;
        if (dut_res !== mk(1, 2, 1, 0)) begin
            miscompares++;
            $display("FAIL ineligible: got %h want %h", dut_res, mk(1, 2, 1, 0));
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NUM_INT; i++)
                set_slot(i, ($urandom % 8) == 0, ($urandom % 8) != 0, $urandom % 8, 1'($urandom));
            clic_mintthresh   = 3'($urandom % 5);
            ctrl_arb_int_hold = ($urandom % 6) == 0;
            tick(1);
            vectors++;
            if (dut_res !== m_out) begin
                miscompares++;
                $display("FAIL random[%0d]: got %h want %h", n, dut_res, m_out);
            end
        end
        ctrl_arb_int_hold = 1'b0;
        clear_all();
        tick(LAT);
        vectors++;
        if (dut_res !== res_t'(0)) begin
            miscompares++;
            $display("FAIL random_drain: got %h want %h", dut_res, res_t'(0));
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_threshold();
        test_hold();
        test_ineligible();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
